hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 8-bit, 16-register, five-stage core. It drives the enable and flush/bubble inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch flushes, memory wait states with a timeout, and halt draining. All enable/bubble outputs are combinational from registered state plus current inputs; state, counters and status flags are registered.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 8-bit, 16-register, five-stage core.
// Drives the PC and IF/ID, ID/EX, EX/MEM, MEM/WB register enables plus the IF/ID flush
// and ID/EX bubble controls. Resolves memory wait states (with timeout), taken-branch
// squashes, load-use stalls and halt draining.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   id_rs1_addr/id_rs2_addr      source registers of the instruction in ID
//   id_rs1_used/id_rs2_used      corresponding source is actually read
//   id_halt                      instruction in ID is HALT
//   ex_mem_read, ex_rd_addr      instruction in EX is a load, and its destination
//   ex_branch_taken              instruction in EX redirects the PC
//   mem_req, mem_ready           MEM-stage data access and its completion
//   pc_en .. memwb_en            pipeline register enables (combinational)
//   ifid_flush, idex_bubble      load NOP into IF/ID, zeroed controls into ID/EX
//   halted, mem_err              terminal status flags
//   stall_cnt                    saturating count of freeze and load-use stall cycles
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs1_addr,
    input  logic [3:0]  id_rs2_addr,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        id_halt,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd_addr,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT);
    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WaitW-1:0]  WaitLast  = WaitW'(MEM_TIMEOUT - 1);
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StDrain, StHalted, StError} state_e;

    state_e             state_q;
    logic [WaitW-1:0]   wait_q;
    logic [DrainW-1:0]  drain_q;
    logic [15:0]        stall_q;

    logic active;
    logic in_run;
    logic freeze;
    logic load_use;
    logic take_branch;
    logic take_load_use;
    logic take_halt;
    logic drain_step;

    // Decision priority: freeze > branch > load-use > halt > normal flow.
    always_comb begin
        active   = (state_q == StRun) || (state_q == StDrain);
        in_run   = (state_q == StRun);
        freeze   = active && mem_req && !mem_ready;
        // r0 is hardwired zero, so a load into it never feeds a dependent.
        load_use = ex_mem_read && (ex_rd_addr != 4'd0) &&
                   ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                    (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
        take_branch   = in_run && !freeze && ex_branch_taken;
        take_load_use = in_run && !freeze && !ex_branch_taken && load_use;
        take_halt     = in_run && !freeze && !ex_branch_taken && !load_use && id_halt;
        drain_step    = (state_q == StDrain) && !freeze;
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (!active || freeze) begin
            // Everything held; defaults apply.
        end else if (drain_step || take_load_use || take_halt) begin
            // Hold PC and IF/ID, push a bubble into EX, let older work retire.
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = take_branch;
            idex_bubble = take_branch;
        end
    end

    assign halted    = !rst && (state_q == StHalted);
    assign mem_err   = !rst && (state_q == StError);
    assign stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            wait_q  <= '0;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            wait_q <= freeze ? (wait_q + WaitW'(1)) : '0;

            if ((freeze || take_load_use) && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end

            if (freeze && (wait_q == WaitLast)) begin
                state_q <= StError;
            end else if (take_halt) begin
                state_q <= StDrain;
                drain_q <= DrainLoad;
            end else if (drain_step) begin
                if (drain_q == '0) begin
                    state_q <= StHalted;
                end else begin
                    drain_q <= drain_q - DrainW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run checked
// against a behavioural model that tracks the core mode, freeze run length, remaining
// drain cycles and stall total.
module tb_hazard_ctrl;

    localparam int MemTimeout  = 16;
    localparam int DrainCycles = 3;

    localparam int ModeRun = 0, ModeDrain = 1, ModeHalted = 2, ModeError = 3;
    localparam int ActReset = 0, ActIdle = 1, ActFreeze = 2, ActDrain = 3,
                   ActSquash = 4, ActStall = 5, ActHalt = 6, ActNormal = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
    logic        id_rs1_used = 0, id_rs2_used = 0, id_halt = 0, ex_mem_read = 0;
    logic        ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble;
    logic        halted, mem_err;
    logic [15:0] stall_cnt;
    logic [6:0]  outs;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_mode = ModeRun, m_wait = 0, m_drain_left = 0, m_stalls = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MemTimeout), .DRAIN_CYCLES(DrainCycles)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble};

    // What the pipeline does this cycle, decided from the rules in priority order.
    function automatic int model_action();
        bit hz;
        hz = ex_mem_read && (ex_rd_addr != 0) &&
             ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
              (id_rs2_used && id_rs2_addr == ex_rd_addr));
        if (rst) return ActReset;
        if (m_mode == ModeHalted || m_mode == ModeError) return ActIdle;
        if (mem_req && !mem_ready) return ActFreeze;
        if (m_mode == ModeDrain) return ActDrain;
        if (ex_branch_taken) return ActSquash;
        if (hz) return ActStall;
        if (id_halt) return ActHalt;
        return ActNormal;
    endfunction

    // {pc, ifid, idex, exmem, memwb, flush, bubble} per action.
    function automatic logic [6:0] action_outs(int act);
        case (act)
            ActReset:                    return 7'b0000011;
            ActDrain, ActStall, ActHalt: return 7'b0011101;
            ActSquash:                   return 7'b1111111;
            ActNormal:                   return 7'b1111100;
            default:                     return 7'b0000000;
        endcase
    endfunction

    function automatic int next_mode();
        int act;
        act = model_action();
        if (act == ActReset) return ModeRun;
        if (act == ActFreeze && m_wait + 1 == MemTimeout) return ModeError;
        if (act == ActHalt) return ModeDrain;
        if (act == ActDrain && m_drain_left == 1) return ModeHalted;
        return m_mode;
    endfunction

    function automatic int next_drain_left();
        int act;
        act = model_action();
        if (act == ActReset) return 0;
        if (act == ActHalt) return DrainCycles;
        if (act == ActDrain) return m_drain_left - 1;
        return m_drain_left;
    endfunction

    function automatic int next_stalls();
        int act;
        act = model_action();
        if (act == ActReset) return 0;
        if (act == ActFreeze || act == ActStall) return (m_stalls < 65535) ? m_stalls + 1 : 65535;
        return m_stalls;
    endfunction

    always @(posedge clk) begin
        m_mode       <= next_mode();
        m_wait       <= (model_action() == ActFreeze) ? m_wait + 1 : 0;
        m_drain_left <= next_drain_left();
        m_stalls     <= next_stalls();
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_halt = 0; ex_mem_read = 0; ex_rd_addr = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    task automatic set_load_use(input logic [3:0] rd);
        ex_mem_read = 1; ex_rd_addr = rd; id_rs2_addr = rd; id_rs2_used = 1;
        id_rs1_addr = rd + 4'd1; id_rs1_used = 1;
    endtask

    task automatic test_reset();
        next_cycle();
        set_idle();
        rst = 1;
        @(negedge clk);
        checks++; if (outs !== 7'b0000011) begin failures++;
            $display("FAIL rst_outs: got %b want %b", outs, 7'b0000011); end
        checks++; if (halted !== 1'b0 || mem_err !== 1'b0) begin failures++;
            $display("FAIL rst_flags: got halted=%b mem_err=%b want 0 0", halted, mem_err); end
        next_cycle();
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd0) begin failures++;
            $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++; if (outs !== 7'b1111100) begin failures++;
            $display("FAIL rst_release_outs: got %b want %b", outs, 7'b1111100); end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(4'd5);
        @(negedge clk);
        checks++; if (outs !== 7'b0011101) begin failures++;
            $display("FAIL lu_stall_outs: got %b want %b", outs, 7'b0011101); end
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++; if (outs !== 7'b1111100 || stall_cnt !== 16'd1) begin failures++;
            $display("FAIL lu_after: got outs=%b cnt=%0d want 1111100 1", outs, stall_cnt); end
        next_cycle();
        set_load_use(4'd0);
        id_rs1_addr = 4'd0;
        @(negedge clk);
        checks++; if (outs !== 7'b1111100) begin failures++;
            $display("FAIL lu_r0_outs: got %b want %b", outs, 7'b1111100); end
        next_cycle();
        // Matching address but source not read: no hazard.
        set_idle();
        ex_mem_read = 1; ex_rd_addr = 4'd9; id_rs1_addr = 4'd9; id_rs2_addr = 4'd9;
        @(negedge clk);
        checks++; if (outs !== 7'b1111100) begin failures++;
            $display("FAIL lu_unused_outs: got %b want %b", outs, 7'b1111100); end
        next_cycle();
        set_idle();
        ex_mem_read = 1; ex_rd_addr = 4'd9; id_rs1_addr = 4'd9; id_rs1_used = 1;
        @(negedge clk);
        checks++; if (outs !== 7'b0011101 || stall_cnt !== 16'd1) begin failures++;
            $display("FAIL lu_rs1: got outs=%b cnt=%0d want 0011101 1", outs, stall_cnt); end
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd2) begin failures++;
            $display("FAIL lu_rs1_cnt: got %0d want 2", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        set_load_use(4'd5);
        id_halt = 1; ex_branch_taken = 1;
        @(negedge clk);
        checks++; if (outs !== 7'b1111111) begin failures++;
            $display("FAIL br_outs: got %b want %b", outs, 7'b1111111); end
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++; if (outs !== 7'b1111100 || stall_cnt !== 16'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL br_after: got outs=%b cnt=%0d halted=%b want 1111100 0 0",
                     outs, stall_cnt, halted); end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_req = 1; mem_ready = 0;
            @(negedge clk);
            checks++; if (outs !== 7'b0000000) begin failures++;
                $display("FAIL wait_outs[%0d]: got %b want 0000000", i, outs); end
            next_cycle();
        end
        mem_req = 1; mem_ready = 1;
        @(negedge clk);
        checks++; if (outs !== 7'b1111100 || stall_cnt !== 16'd4 || mem_err !== 1'b0) begin
            failures++;
            $display("FAIL wait_release: got outs=%b cnt=%0d err=%b want 1111100 4 0",
                     outs, stall_cnt, mem_err); end
        next_cycle();
        // Freeze concurrent with a load-use: freeze first, stall on the next cycle.
        set_load_use(4'd7);
        mem_req = 1; mem_ready = 0;
        @(negedge clk);
        checks++; if (outs !== 7'b0000000) begin failures++;
            $display("FAIL wait_lu_frozen: got %b want 0000000", outs); end
        next_cycle();
        mem_req = 0;
        @(negedge clk);
        checks++; if (outs !== 7'b0011101 || stall_cnt !== 16'd5) begin failures++;
            $display("FAIL wait_lu_stall: got outs=%b cnt=%0d want 0011101 5", outs, stall_cnt); end
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++; if (outs !== 7'b1111100 || stall_cnt !== 16'd6) begin failures++;
            $display("FAIL wait_lu_after: got outs=%b cnt=%0d want 1111100 6", outs, stall_cnt); end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        // Ready arriving on the last tolerated cycle avoids the error.
        for (int i = 0; i < MemTimeout - 1; i++) begin
            mem_req = 1; mem_ready = 0;
            next_cycle();
        end
        mem_req = 1; mem_ready = 1;
        @(negedge clk);
        checks++; if (outs !== 7'b1111100) begin failures++;
            $display("FAIL tmo_near_outs: got %b want 1111100", outs); end
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++; if (mem_err !== 1'b0 || outs !== 7'b1111100) begin failures++;
            $display("FAIL tmo_near_err: got err=%b outs=%b want 0 1111100", mem_err, outs); end
        next_cycle();
        for (int i = 0; i < MemTimeout; i++) begin
            mem_req = 1; mem_ready = 0;
            @(negedge clk);
            checks++; if (outs !== 7'b0000000 || mem_err !== 1'b0) begin failures++;
                $display("FAIL tmo_wait[%0d]: got outs=%b err=%b want 0000000 0",
                         i, outs, mem_err); end
            next_cycle();
        end
        set_idle();
        @(negedge clk);
        checks++; if (mem_err !== 1'b1 || outs !== 7'b0000000) begin failures++;
            $display("FAIL tmo_err: got err=%b outs=%b want 1 0000000", mem_err, outs); end
        next_cycle();
        ex_branch_taken = 1; mem_req = 1; mem_ready = 1;
        @(negedge clk);
        checks++; if (mem_err !== 1'b1 || outs !== 7'b0000000) begin failures++;
            $display("FAIL tmo_sticky: got err=%b outs=%b want 1 0000000", mem_err, outs); end
        next_cycle();
        set_idle();
        rst = 1;
        @(negedge clk);
        checks++; if (mem_err !== 1'b0 || outs !== 7'b0000011) begin failures++;
            $display("FAIL tmo_rst: got err=%b outs=%b want 0 0000011", mem_err, outs); end
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++; if (outs !== 7'b1111100) begin failures++;
            $display("FAIL tmo_resume: got %b want 1111100", outs); end
        next_cycle();
    endtask

    task automatic test_halt();
        logic [6:0] want;
        // Halt with a 2-cycle freeze inside the drain: halted at t+6.
        do_reset();
        id_halt = 1;
        @(negedge clk);
        checks++; if (outs !== 7'b0011101) begin failures++;
            $display("FAIL halt_t: got %b want 0011101", outs); end
        next_cycle();
        for (int k = 1; k <= 7; k++) begin
            set_idle();
            if (k == 1) begin set_load_use(4'd3); id_halt = 1; ex_branch_taken = 1; end
            if (k == 2 || k == 3) begin mem_req = 1; mem_ready = 0; end
            want = (k == 2 || k == 3 || k >= 6) ? 7'b0000000 : 7'b0011101;
            @(negedge clk);
            checks++; if (outs !== want || halted !== (k >= 6)) begin failures++;
                $display("FAIL halt_wait[t+%0d]: got outs=%b halted=%b want %b %b",
                         k, outs, halted, want, (k >= 6)); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd2) begin failures++;
            $display("FAIL halt_wait_cnt: got %0d want 2", stall_cnt); end
        next_cycle();
        // Plain halt: halted from t+DrainCycles+1.
        do_reset();
        id_halt = 1;
        next_cycle();
        set_idle();
        for (int k = 1; k <= DrainCycles + 1; k++) begin
            want = (k <= DrainCycles) ? 7'b0011101 : 7'b0000000;
            @(negedge clk);
            checks++; if (outs !== want || halted !== (k > DrainCycles)) begin failures++;
                $display("FAIL halt_plain[t+%0d]: got outs=%b halted=%b want %b %b",
                         k, outs, halted, want, (k > DrainCycles)); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        set_load_use(4'd6);
        next_cycle();
        set_idle();
        id_halt = 1;
        next_cycle();
        set_idle();
        @(negedge clk);
        checks++; if (outs !== 7'b0011101) begin failures++;
            $display("FAIL rmd_drain: got %b want 0011101", outs); end
        next_cycle();
        rst = 1;
        @(negedge clk);
        checks++; if (outs !== 7'b0000011 || halted !== 1'b0) begin failures++;
            $display("FAIL rmd_rst: got outs=%b halted=%b want 0000011 0", outs, halted); end
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++; if (outs !== 7'b1111100 || stall_cnt !== 16'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL rmd_resume: got outs=%b cnt=%0d halted=%b want 1111100 0 0",
                     outs, stall_cnt, halted); end
        next_cycle();
        // Reset mid-freeze: wait run length starts over afterwards.
        for (int i = 0; i < 10; i++) begin mem_req = 1; mem_ready = 0; next_cycle(); end
        rst = 1;
        next_cycle();
        rst = 0;
        for (int i = 0; i < MemTimeout - 1; i++) begin mem_req = 1; mem_ready = 0; next_cycle(); end
        set_idle();
        @(negedge clk);
        checks++; if (mem_err !== 1'b0 || outs !== 7'b1111100) begin failures++;
            $display("FAIL rmf_no_err: got err=%b outs=%b want 0 1111100", mem_err, outs); end
        next_cycle();
    endtask

    task automatic test_random();
        int stuck_left;
        logic [6:0] want;
        stuck_left = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            ex_mem_read     = $urandom_range(0, 1) == 1;
            ex_rd_addr      = 4'($urandom_range(0, 3));
            id_rs1_addr     = 4'($urandom_range(0, 3));
            id_rs2_addr     = 4'($urandom_range(0, 3));
            id_rs1_used     = $urandom_range(0, 1) == 1;
            id_rs2_used     = $urandom_range(0, 1) == 1;
            id_halt         = ($urandom_range(0, 19) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            if (stuck_left == 0 && $urandom_range(0, 149) == 0) stuck_left = 20;
            mem_req   = (stuck_left > 0) || ($urandom_range(0, 2) == 0);
            mem_ready = (stuck_left == 0) && ($urandom_range(0, 3) != 0);
            if (stuck_left > 0) stuck_left--;
            want = action_outs(model_action());
            @(negedge clk);
            checks++; if (outs !== want) begin failures++;
                $display("FAIL rnd_outs[%0d]: got %b want %b", n, outs, want); end
            checks++; if (halted !== (!rst && m_mode == ModeHalted) ||
                          mem_err !== (!rst && m_mode == ModeError)) begin failures++;
                $display("FAIL rnd_flags[%0d]: got halted=%b err=%b mode=%0d", n, halted,
                         mem_err, m_mode); end
            checks++; if (stall_cnt !== 16'(m_stalls)) begin failures++;
                $display("FAIL rnd_stall_cnt[%0d]: got %0d want %0d", n, stall_cnt, m_stalls); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
